// File: rtl/ssd_scan_display.sv
// Time-multiplexed seven-segment driver: round-robin digit scan with a dark
// gap at the end of each slot, a per-frame snapshot, and leading-zero blanking.
module ssd_scan_display #(
    parameter int DIGITS = 4,
    parameter int DIV    = 100000,
    parameter int DEAD   = 2000,
    parameter int CW     = 17
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  freeze,
    input  logic                  lz_en,
    input  logic                  blank,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            cathodes,
    output logic                  dp,
    output logic                  frame_tick
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW:0]   DRIVE_END = (CW + 1)'(DIV - DEAD);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    generate
        if (DIGITS < 1 || DIGITS > 8 || DEAD < 0 || DIV < DEAD + 2 ||
            (64'(1) << CW) < 64'(DIV)) begin : g_bad_cfg
            $error("ssd_scan_display: illegal DIGITS/DIV/DEAD/CW combination");
        end
    endgenerate

    typedef enum logic {
        PH_DRIVE = 1'b0,
        PH_DEAD  = 1'b1
    } phase_e;

    // Debug view of the scan state machine: digit index, slot counter, phase.
    typedef struct packed {
        logic [IW-1:0] idx;
        logic [CW-1:0] cnt;
        phase_e        phase;
    } scan_state_t;

    scan_state_t scan_state;

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] snap_q, snap_d;
    logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          cathodes_q, cathodes_d;
    logic                dp_q, dp_d;
    logic                frame_tick_q, frame_tick_d;

    logic                slot_end;
    logic                frame_wrap;
    logic [DIGITS-1:0]   tail_zero;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_tail_zero;
    logic                suppress;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    always_comb begin
        scan_state.idx   = idx_q;
        scan_state.cnt   = cnt_q;
        scan_state.phase = ({1'b0, cnt_q} < DRIVE_END) ? PH_DRIVE : PH_DEAD;

        slot_end   = (scan_state.cnt == CNT_LAST);
        frame_wrap = slot_end && (scan_state.idx == IDX_LAST);

        cnt_d = slot_end ? '0 : scan_state.cnt + 1'b1;
        if (frame_wrap) begin
            idx_d = '0;
        end else if (slot_end) begin
            idx_d = scan_state.idx + 1'b1;
        end else begin
            idx_d = scan_state.idx;
        end

        // The snapshot only moves at frame wrap so a frame never mixes two values.
        snap_d    = snap_q;
        snap_dp_d = snap_dp_q;
        if (frame_wrap && !freeze) begin
            snap_d    = value;
            snap_dp_d = dp_mask;
        end
        frame_tick_d = frame_wrap;

        // tail_zero[i]: snapshot nibbles i..DIGITS-1 are all zero.
        tail_zero[DIGITS-1] = (snap_q[4*DIGITS-1 -: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            tail_zero[i] = tail_zero[i+1] && (snap_q[4*i +: 4] == 4'h0);
        end

        cur_nib       = 4'h0;
        cur_dp        = 1'b0;
        cur_tail_zero = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_state.idx == IW'(i)) begin
                cur_nib       = snap_q[4*i +: 4];
                cur_dp        = snap_dp_q[i];
                cur_tail_zero = tail_zero[i];
            end
        end
        suppress = lz_en && (scan_state.idx != '0) && cur_tail_zero && !cur_dp;

        an_d       = '1;
        cathodes_d = 7'h7F;
        dp_d       = 1'b1;
        if (scan_state.phase == PH_DRIVE && !blank && !suppress) begin
            for (int i = 0; i < DIGITS; i++) begin
                an_d[i] = (scan_state.idx != IW'(i));
            end
            cathodes_d = hex7(cur_nib);
            dp_d       = ~cur_dp;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            snap_q       <= '0;
            snap_dp_q    <= '0;
            an_q         <= '1;
            cathodes_q   <= 7'h7F;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            snap_dp_q    <= snap_dp_d;
            an_q         <= an_d;
            cathodes_q   <= cathodes_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign cathodes   = cathodes_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: doc/ssd_scan_display.md
Name: ssd_scan_display

Overview:
- Parametrised, time-multiplexed seven-segment display driver for DIGITS hex digits.
- Captures a display value and decimal-point mask into an internal snapshot once per frame, so the display never tears mid-frame.
- Scans the digits round-robin with a programmable dead time between digits to suppress ghosting.
- Supports leading-zero suppression and global blanking. Sits between the CPU debug-mux (PC/register readout) and the board anodes/cathodes.
- Generalises the fixed 4-digit, fixed-rate display path.

Parameters:
- DIGITS, 4: number of digits (1..8); value width is 4*DIGITS.
- DIV, 100000: clock cycles per digit slot (>= DEAD+2).
- DEAD, 2000: cycles at the end of each slot with all anodes off (0..DIV-2).
- CW, 17: width of the slot counter; must satisfy 2^CW >= DIV.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- value  in  4*DIGITS  hex value to display; nibble i drives digit i.
- dp_mask  in  DIGITS  decimal point per digit, 1 = lit.
- freeze  in  1  1 = keep the current snapshot at frame wrap.
- lz_en  in  1  1 = suppress leading zeros.
- blank  in  1  1 = all digits dark; scanning continues.
- an  out  DIGITS  anodes, active low; an[i] selects digit i.
- cathodes  out  7  segments, active low; bit0=a ... bit6=g.
- dp  out  1  decimal point, active low.
- frame_tick  out  1  one-cycle pulse on frame wrap.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: an = all 1, cathodes = 7'h7F, dp = 1, frame_tick = 0.
  - Internal state: slot counter cnt = 0, digit index idx = 0, snapshot value/dp = 0.
- State: the (idx, cnt) pair forms the state machine. Each digit slot has a DRIVE phase for cnt in 0..DIV-DEAD-1, then a DEAD phase for cnt in DIV-DEAD..DIV-1.
- Counter advance, every edge:
  - If cnt == DIV-1: cnt <= 0 and idx <= (idx == DIGITS-1) ? 0 : idx+1.
  - Otherwise: cnt <= cnt+1.
- Outputs are registered, with one cycle of latency from (idx, cnt). On each edge the outputs load the values for the pre-edge (idx, cnt):
  - DRIVE phase with digit not suppressed and blank = 0:
    - an = all 1 except bit idx = 0.
    - cathodes = hex7(snap nibble idx).
    - dp = ~snap_dp[idx].
  - DEAD phase, or blank = 1, or digit suppressed: an = all 1, cathodes = 7'h7F, dp = 1.
- Result: the first rising edge after reset release drives digit 0 for exactly DIV-DEAD cycles, followed by DEAD dark cycles.
- hex7 encoding (active-low {g..a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Snapshot update:
  - Happens on the edge where idx wraps from DIGITS-1 to 0 (cnt == DIV-1).
  - If freeze = 0: snap <= value and snap_dp <= dp_mask. If freeze = 1: snapshot is held.
  - value changes mid-frame never reach the display before the next wrap.
  - The first frame after reset shows the reset snapshot (0).
- frame_tick:
  - Registered, high for exactly one cycle, the cycle after the wrap edge.
  - Pulses regardless of freeze and blank.
- Leading-zero suppression (lz_en = 1):
  - Digit i > 0 is suppressed iff snap nibbles i..DIGITS-1 are all zero and snap_dp[i] = 0.
  - Digit 0 is never suppressed.
  - lz_en and blank are sampled live, not snapshotted.
- Boundary conditions:
  - DIGITS = 1: idx stays 0; a wrap occurs every DIV cycles.
  - DEAD = 0: no dark gap; an switches directly between adjacent digits.
  - Reset asserted mid-slot: outputs go dark immediately (asynchronously); scanning restarts at digit 0, cnt 0.
- Elaboration check: the module stops elaboration if DIV < DEAD+2 or 2^CW < DIV.

Test Plan:
- Bench configuration: DIGITS=4, DIV=8, DEAD=2, CW=3.
- Reset check: hold reset=0 with value=16'h1234 -> an=4'hF, cathodes=7F, dp=1.
  - Release reset -> an=4'hE for 6 cycles, then 4'hF for 2 cycles, then 4'hD, and so on, with cathodes=40 (0) throughout.
  - frame_tick pulses after 32 cycles.
  - The second frame shows digits 4,3,2,1 on an[0..3] (cathodes 19, 30, 24, 79).
- Freeze/tearing: change value 1234 -> ABCD mid-frame with freeze=0 -> the current frame still shows 1234 and the next frame shows d,C,b,A (21, 46, 03, 08).
  - Repeat with freeze=1 -> the display stays 1234 indefinitely.
- Leading-zero suppression: value=0005, lz_en=1 -> only an[0] ever goes low, cathodes=12.
  - value=0000 -> digit 0 shows 40.
  - dp_mask=4'b0100 with value=0005 -> digits 0 and 2 lit; digit 2 shows 40 with dp=0.
- Blanking: blank=1 for 20 cycles -> an=4'hF throughout.
  - frame_tick still pulses on schedule.
  - Deassert blank -> the digit resumes in the correct slot position.
- Reset mid-operation: assert reset at cycle 13 (digit 1 DRIVE) -> an=4'hF within the same cycle, without waiting for a clock edge.
  - Release reset -> scanning restarts at digit 0 and the snapshot reads 0000.
